keypad_scan4x4: RTL and testbench

- Scans a 4x4 matrix keypad by driving one active-low row at a time and sampling the four active-low columns. This is the input-side counterpart to the multiplexed 7-segment output.
- Debounces whole-keypad scan maps, emits one code per clean single-key press, and shifts each code into a 4-digit entry register.
- o_entry feeds sseg4 i_bin, or a datapath operand such as bab_2_3_5 i_n, in the board top.

---
 rtl/keypad_scan4x4.sv | 172 +++++++++++++++++
 tb/tb_keypad_scan4x4.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner: one active-low row at a time, whole-map debounce,
// single-key decode and a four-digit shift-in entry register.
module keypad_scan4x4 #(
   parameter int ROW_TICKS = 100000,
   parameter int DB_SCANS  = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic [3:0]  o_row_n,
   input  logic [3:0]  i_col_n,
   input  logic        i_clear,
   output logic        o_key_valid,
   output logic [3:0]  o_key_code,
   output logic        o_key_held,
   output logic [15:0] o_entry
);

   localparam int DW_W = $clog2(ROW_TICKS);
   localparam int DB_W = (DB_SCANS > 2) ? $clog2(DB_SCANS) : 1;
   localparam logic [DW_W-1:0] DW_LAST  = DW_W'(ROW_TICKS - 1);
   localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_SCANS - 1);

   typedef enum logic [1:0] {S_IDLE, S_HELD, S_LOCK} state_t;

   logic [3:0]      r_col_s1, r_col_s2;
   logic [DW_W-1:0] r_dwell;
   logic [1:0]      r_row;
   logic [3:0]      r_row_n;
   logic [15:0]     r_scan_map, r_prev_map, r_stable_map;
   logic [DB_W-1:0] r_stable_cnt;
   logic            r_stable_upd;
   state_t          r_state;
   logic            r_key_valid, r_key_held;
   logic [3:0]      r_key_code;
   logic [15:0]     r_entry;

   logic [3:0]      w_col;
   logic            w_row_end, w_scan_end;
   logic [1:0]      w_row_next;
   logic [15:0]     w_new_map;
   logic [DB_W-1:0] w_cnt_next;
   logic            w_one_hot, w_map_zero;
   logic [3:0]      w_idx, w_code;

   function automatic logic [3:0] f_decode(input logic [3:0] idx);
      logic [3:0] code;
      case (idx)
         4'd0:  code = 4'h1;
         4'd1:  code = 4'h2;
         4'd2:  code = 4'h3;
         4'd3:  code = 4'hA;
         4'd4:  code = 4'h4;
         4'd5:  code = 4'h5;
         4'd6:  code = 4'h6;
         4'd7:  code = 4'hB;
         4'd8:  code = 4'h7;
         4'd9:  code = 4'h8;
         4'd10: code = 4'h9;
         4'd11: code = 4'hC;
         4'd12: code = 4'hE;
         4'd13: code = 4'h0;
         4'd14: code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   assign w_col      = ~r_col_s2;
   assign w_row_end  = (r_dwell == DW_LAST);
   assign w_scan_end = w_row_end && (r_row == 2'd3);
   assign w_row_next = r_row + 2'd1;

   always_comb begin
      w_new_map = r_scan_map;
      w_new_map[{r_row, 2'b00} +: 4] = w_col;
   end

   // Saturating count of consecutive identical full-scan maps
   always_comb begin
      w_cnt_next = '0;
      if (w_new_map == r_prev_map)
         w_cnt_next = (r_stable_cnt == CNT_LAST) ? CNT_LAST : r_stable_cnt + DB_W'(1);
   end

   always_comb begin
      w_idx = 4'd0;
      for (int i = 0; i < 16; i++)
         if (r_stable_map[i]) w_idx = 4'(i);
   end

   assign w_map_zero = (r_stable_map == 16'd0);
   assign w_one_hot  = !w_map_zero && ((r_stable_map & (r_stable_map - 16'd1)) == 16'd0);
   assign w_code     = f_decode(w_idx);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_col_s1     <= 4'hF;
         r_col_s2     <= 4'hF;
         r_dwell      <= '0;
         r_row        <= 2'd0;
         r_row_n      <= 4'b1110;
         r_scan_map   <= '0;
         r_prev_map   <= '0;
         r_stable_map <= '0;
         r_stable_cnt <= '0;
         r_stable_upd <= 1'b0;
      end else begin
         r_col_s1     <= i_col_n;
         r_col_s2     <= r_col_s1;
         r_stable_upd <= 1'b0;
         if (w_row_end) begin
            r_dwell    <= '0;
            r_row      <= w_row_next;
            r_row_n    <= ~(4'b0001 << w_row_next);
            r_scan_map <= w_new_map;
            if (w_scan_end) begin
               r_prev_map   <= w_new_map;
               r_stable_cnt <= w_cnt_next;
               if (w_cnt_next == CNT_LAST) begin
                  r_stable_map <= w_new_map;
                  r_stable_upd <= 1'b1;
               end
            end
         end else begin
            r_dwell <= r_dwell + DW_W'(1);
         end
      end
   end

   // Key FSM acts only on a freshly debounced map; clear beats the entry shift
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_key_valid <= 1'b0;
         r_key_code  <= 4'h0;
         r_key_held  <= 1'b0;
         r_entry     <= 16'h0000;
      end else begin
         r_key_valid <= 1'b0;
         if (i_clear) r_entry <= 16'h0000;
         if (r_stable_upd) begin
            case (r_state)
               S_IDLE: begin
                  if (w_one_hot) begin
                     r_state     <= S_HELD;
                     r_key_held  <= 1'b1;
                     r_key_valid <= 1'b1;
                     r_key_code  <= w_code;
                     if (!i_clear) r_entry <= {r_entry[11:0], w_code};
                  end else if (!w_map_zero) begin
                     r_state    <= S_LOCK;
                     r_key_held <= 1'b1;
                  end
               end
               default: begin
                  if (w_map_zero) begin
                     r_state    <= S_IDLE;
                     r_key_held <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

   assign o_row_n     = r_row_n;
   assign o_key_valid = r_key_valid;
   assign o_key_code  = r_key_code;
   assign o_key_held  = r_key_held;
   assign o_entry     = r_entry;

endmodule

// File: tb/tb_keypad_scan4x4.sv
// Directed bench for keypad_scan4x4 with a matrix keypad model (ROW_TICKS=4, DB_SCANS=3).
module tb_keypad_scan4x4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic        clear = 1'b0;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic [15:0] entry;

   logic [15:0] keys = 16'h0000;
   int          tb_cyc = 0;
   int          pulse_cnt = 0;
   int          last_pulse_cyc = -1;
   int          n_checks = 0;
   int          n_fail = 0;

   keypad_scan4x4 #(.ROW_TICKS(4), .DB_SCANS(3)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .o_row_n(row_n), .i_col_n(col_n),
      .i_clear(clear), .o_key_valid(key_valid), .o_key_code(key_code),
      .o_key_held(key_held), .o_entry(entry)
   );

   always #5 clk = ~clk;

   // Pressed key at (r,c) pulls column c low while row r is driven low
   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row_n[r] && keys[4*r+c]) col_n[c] = 1'b0;
   end

   always @(posedge clk) begin
      if (!rst_n) tb_cyc <= 0;
      else        tb_cyc <= tb_cyc + 1;
   end

   always @(negedge clk) begin
      if (key_valid) begin
         pulse_cnt      = pulse_cnt + 1;
         last_pulse_cyc = tb_cyc;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_scan_end();
      int guard = 0;
      do begin
         step();
         guard++;
      end while ((tb_cyc % 16) != 0 && guard < 20);
      if ((tb_cyc % 16) != 0) begin
         n_checks++; n_fail++;
         $display("FAIL scan_timeout: tb_cyc=%0d not at scan boundary", tb_cyc);
      end
   endtask

   task automatic wait_scans(input int n);
      repeat (n) wait_scan_end();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      n_checks++; if (row_n !== 4'b1110) begin n_fail++; $display("FAIL reset_row: got %b want 1110", row_n); end
      n_checks++; if (entry !== 16'h0000) begin n_fail++; $display("FAIL reset_entry: got %h want 0000", entry); end
      n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", key_valid); end
      n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b want 0", key_held); end
      n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_code: got %h want 0", key_code); end
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         logic [3:0] exp_row;
         step();
         exp_row = ~(4'b0001 << ((tb_cyc / 4) % 4));
         n_checks++;
         if (row_n !== exp_row) begin
            n_fail++; $display("FAIL row_step: cyc %0d got %b want %b", tb_cyc, row_n, exp_row);
         end
      end
   endtask

   task automatic test_single_press();
      int p0, base;
      wait_scan_end();
      p0 = pulse_cnt; base = tb_cyc;
      keys = 16'h0001 << 5;
      wait_scans(10);
      n_checks++; if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL press5_count: got %0d want 1", pulse_cnt - p0); end
      n_checks++; if (last_pulse_cyc != base + 49) begin n_fail++; $display("FAIL press5_latency: got %0d want %0d", last_pulse_cyc, base + 49); end
      n_checks++; if (key_code !== 4'h5) begin n_fail++; $display("FAIL press5_code: got %h want 5", key_code); end
      n_checks++; if (entry !== 16'h0005) begin n_fail++; $display("FAIL press5_entry: got %h want 0005", entry); end
      n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL press5_held: got %b want 1", key_held); end
      keys = 16'h0000;
      wait_scans(3);
      n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL release5_early: got %b want 1", key_held); end
      step();
      n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL release5_held: got %b want 0", key_held); end
   endtask

   task automatic test_entry_sequence();
      int p0;
      logic [3:0] bits [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
      p0 = pulse_cnt;
      for (int k = 0; k < 5; k++) begin
         wait_scan_end();
         keys = 16'h0001 << bits[k];
         wait_scans(4);
         keys = 16'h0000;
         wait_scans(4);
         if (k == 3) begin
            n_checks++; if (entry !== 16'h123A) begin n_fail++; $display("FAIL entry_123A: got %h want 123A", entry); end
         end
      end
      n_checks++; if (entry !== 16'h23A7) begin n_fail++; $display("FAIL entry_23A7: got %h want 23A7", entry); end
      n_checks++; if (pulse_cnt - p0 != 5) begin n_fail++; $display("FAIL entry_count: got %0d want 5", pulse_cnt - p0); end
   endtask

   task automatic test_bounce();
      int p0;
      wait_scan_end();
      p0 = pulse_cnt;
      for (int k = 0; k < 5; k++) begin
         keys = (k % 2 == 0) ? (16'h0001 << 10) : 16'h0000;
         wait_scan_end();
      end
      n_checks++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL bounce_toggle: got %0d pulses want 0", pulse_cnt - p0); end
      wait_scans(2);
      n_checks++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL bounce_early: got %0d pulses want 0", pulse_cnt - p0); end
      step();
      n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL bounce_valid: got %b want 1", key_valid); end
      n_checks++; if (key_code !== 4'h9) begin n_fail++; $display("FAIL bounce_code: got %h want 9", key_code); end
      n_checks++; if (entry !== 16'h3A79) begin n_fail++; $display("FAIL bounce_entry: got %h want 3A79", entry); end
      keys = 16'h0000;
      wait_scans(4);
   endtask

   task automatic test_multikey();
      int p0;
      wait_scan_end();
      p0 = pulse_cnt;
      keys = (16'h0001 << 0) | (16'h0001 << 6);
      wait_scans(4);
      n_checks++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL multi_pulse: got %0d pulses want 0", pulse_cnt - p0); end
      n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL multi_lock: got %b want 1", key_held); end
      keys = 16'h0001;
      wait_scans(4);
      n_checks++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL multi_partial: got %0d pulses want 0", pulse_cnt - p0); end
      n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL multi_partial_held: got %b want 1", key_held); end
      keys = 16'h0000;
      wait_scans(4);
      n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL multi_idle: got %b want 0", key_held); end
      keys = 16'h0001 << 13;
      wait_scans(4);
      n_checks++; if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL zero_count: got %0d want 1", pulse_cnt - p0); end
      n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL zero_code: got %h want 0", key_code); end
      n_checks++; if (entry !== 16'hA790) begin n_fail++; $display("FAIL zero_entry: got %h want A790", entry); end
      keys = 16'h0000;
      wait_scans(4);
   endtask

   task automatic test_clear_coincident();
      wait_scan_end();
      keys = 16'h0001 << 14;
      wait_scans(3);
      clear = 1'b1;
      step();
      clear = 1'b0;
      n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL clear_valid: got %b want 1", key_valid); end
      n_checks++; if (key_code !== 4'hF) begin n_fail++; $display("FAIL clear_code: got %h want F", key_code); end
      n_checks++; if (entry !== 16'h0000) begin n_fail++; $display("FAIL clear_entry: got %h want 0000", entry); end
      keys = 16'h0000;
      wait_scans(4);
   endtask

   task automatic test_reset_midpress();
      int p0;
      wait_scan_end();
      keys = 16'h0001 << 4;
      wait_scans(4);
      n_checks++; if (entry !== 16'h0004) begin n_fail++; $display("FAIL pre_reset_entry: got %h want 0004", entry); end
      repeat (6) step();
      rst_n = 1'b0;
      repeat (2) step();
      n_checks++;
      if ({key_valid, key_code, key_held, entry} !== 22'd0 || row_n !== 4'b1110) begin
         n_fail++; $display("FAIL midreset_outputs: v=%b c=%h h=%b e=%h row=%b want all zero, row 1110",
                            key_valid, key_code, key_held, entry, row_n);
      end
      rst_n = 1'b1;
      p0 = pulse_cnt;
      wait_scans(3);
      n_checks++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL midreset_early: got %0d pulses want 0", pulse_cnt - p0); end
      n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL midreset_held: got %b want 0", key_held); end
      step();
      n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_valid: got %b want 1", key_valid); end
      n_checks++; if (key_code !== 4'h4) begin n_fail++; $display("FAIL midreset_code: got %h want 4", key_code); end
      n_checks++; if (entry !== 16'h0004) begin n_fail++; $display("FAIL midreset_entry: got %h want 0004", entry); end
      keys = 16'h0000;
      wait_scans(4);
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_entry_sequence();
      test_bounce();
      test_multikey();
      test_clear_coincident();
      test_reset_midpress();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
